bin_to_excess3_serial: RTL and testbench

//  Bit-serial BCD-to-excess-3 encoder. Transmit side of the serial excess-3 link.

---
 rtl/bin_to_excess3_serial.sv | 155 +++++++++++++++
 tb/tb_bin_to_excess3_serial.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_excess3_serial.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_excess3_serial
// Description : Bit-serial BCD-to-excess-3 encoder. Consumes an LSB-first
//               stream of 4-bit BCD digits and emits digit+3 (4-bit wrap),
//               LSB-first, one registered cycle later. Frames are NUM_DIGITS
//               digits long; frame_done marks the last output bit of a frame.
//               Optional macro BCD_CHECK_EN enables the digit_err (>9) flag;
//               when undefined digit_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_excess3_serial #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in,
  output logic out,
  output logic out_valid,
  output logic frame_done,
  output logic digit_err
);

  // State encodes the bit position within the digit plus the running carry
  typedef enum logic [2:0] {
    B0   = 3'd0,
    B1C0 = 3'd1,
    B1C1 = 3'd2,
    B2C0 = 3'd3,
    B2C1 = 3'd4,
    B3C0 = 3'd5,
    B3C1 = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] c_last_digit = CNT_W'(NUM_DIGITS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_out_bit;
  logic             w_digit_end;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_frame_done;

  // Serial add of constant 0011: next state and output bit for the current input bit
  always_comb begin
    w_next_state = B0;
    w_out_bit    = 1'b0;
    w_digit_end  = 1'b0;
    case (r_state)
      B0: begin
        w_out_bit    = ~in;
        w_next_state = in ? B1C1 : B1C0;
      end
      B1C0: begin
        w_out_bit    = ~in;
        w_next_state = in ? B2C1 : B2C0;
      end
      B1C1: begin
        w_out_bit    = in;
        w_next_state = B2C1;
      end
      B2C0: begin
        w_out_bit    = in;
        w_next_state = B3C0;
      end
      B2C1: begin
        w_out_bit    = ~in;
        w_next_state = in ? B3C1 : B3C0;
      end
      B3C0: begin
        w_out_bit    = in;
        w_next_state = B0;
        w_digit_end  = 1'b1;
      end
      B3C1: begin
        // Carry out of bit 3 is dropped, giving the 4-bit wrap
        w_out_bit    = ~in;
        w_next_state = B0;
        w_digit_end  = 1'b1;
      end
      default: begin
        w_out_bit    = 1'b0;
        w_next_state = B0;
      end
    endcase
  end

  // State register; advances only on accepted bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= B0;
    end else if (in_valid) begin
      r_state <= w_next_state;
    end
  end

  // Digit counter and registered outputs; out holds its value across stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (in_valid) begin
      r_out        <= w_out_bit;
      r_out_valid  <= 1'b1;
      r_frame_done <= w_digit_end && (r_cnt == c_last_digit);
      if (w_digit_end) begin
        r_cnt <= (r_cnt == c_last_digit) ? '0 : r_cnt + CNT_W'(1);
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

`ifdef BCD_CHECK_EN
  logic r_b1;
  logic r_b2;
  logic r_digit_err;

  // Capture bits 1 and 2 of the digit; flag >9 when bit 3 arrives set with either
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_b1        <= 1'b0;
      r_b2        <= 1'b0;
      r_digit_err <= 1'b0;
    end else if (in_valid) begin
      if (r_state == B1C0 || r_state == B1C1) begin
        r_b1 <= in;
      end
      if (r_state == B2C0 || r_state == B2C1) begin
        r_b2 <= in;
      end
      r_digit_err <= w_digit_end & in & (r_b1 | r_b2);
    end else begin
      r_digit_err <= 1'b0;
    end
  end

  assign digit_err = r_digit_err;
`else
  assign digit_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_excess3_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_excess3_serial
// Description : Self-checking bench for bin_to_excess3_serial. Expected output
//               bits are pushed to a queue as each input bit is driven and
//               popped by a monitor when out_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_excess3_serial;

  localparam int NUM_DIGITS = 4;
  localparam int CNT_W      = 4;

  logic clock;
  logic reset;
  logic in_valid;
  logic in;
  logic out;
  logic out_valid;
  logic frame_done;
  logic digit_err;

  typedef struct packed {
    logic bit_o;
    logic fd;
    logic err;
  } exp_t;

  exp_t q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   model_dig = 0;
  int   fd_count  = 0;

  bin_to_excess3_serial #(
    .NUM_DIGITS(NUM_DIGITS),
    .CNT_W     (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .digit_err (digit_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pops the scoreboard whenever the DUT presents a valid bit
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && out_valid === 1'b1) begin
        if (frame_done === 1'b1) fd_count++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid: out_valid=1 with no pending expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          if ({out, frame_done, digit_err} !== {e.bit_o, e.fd, e.err}) begin
            n_fail++;
            $display("FAIL out_bit: got out/fd/err=%b%b%b expected %b%b%b at %0t",
                     out, frame_done, digit_err, e.bit_o, e.fd, e.err, $time);
          end
        end
      end else if (reset === 1'b1) begin
        n_checks++;
        if ({frame_done, digit_err} !== 2'b00) begin
          n_fail++;
          $display("FAIL idle_pulses: got fd/err=%b%b expected 00 at %0t", frame_done, digit_err, $time);
        end
      end
    end
  endtask

  // Drives nbits of digit d LSB-first; optional stall of stall_n cycles after bit stall_bit
  task automatic send_digit(input int d, input int nbits, input int stall_bit, input int stall_n);
    logic [3:0] dv;
    logic [3:0] ev;
    logic       fd;
    logic       err;
    dv = 4'(d);
    ev = 4'(d + 3);
    fd = (model_dig == NUM_DIGITS - 1);
`ifdef BCD_CHECK_EN
    err = (d > 9);
`else
    err = 1'b0;
`endif
    for (int k = 0; k < nbits; k++) begin
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in       = dv[k];
      q.push_back('{bit_o: ev[k], fd: (fd && k == 3), err: (err && k == 3)});
      if (k == stall_bit) begin
        for (int i = 0; i < stall_n; i++) begin
          @(posedge clock);
          #1;
          in_valid = 1'b0;
          in       = ~dv[k];
          if (i > 0) begin
            n_checks++;
            if ({out_valid, out} !== {1'b0, ev[k]}) begin
              n_fail++;
              $display("FAIL stall_hold: got valid/out=%b%b expected 0%b", out_valid, out, ev[k]);
            end
          end
        end
      end
    end
    if (nbits == 4) model_dig = (model_dig + 1) % NUM_DIGITS;
  endtask

  // Stops driving and waits (bounded) for every expectation to be consumed
  task automatic drain(input string name);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d outputs still pending, expected 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in       = 1'b0;
    reset    = 1'b0;
    #1;
    n_checks++;
    if ({out, out_valid, frame_done, digit_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {out, out_valid, frame_done, digit_err});
    end
    q.delete();
    model_dig = 0;
    fd_count  = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_digit5();
    send_digit(5, 4, -1, 0);
    drain("digit5");
  endtask

  task automatic test_carry_boundary();
    send_digit(0, 4, -1, 0);
    send_digit(9, 4, -1, 0);
    drain("carry");
  endtask

  task automatic test_frame();
    test_reset();
    send_digit(1, 4, -1, 0);
    send_digit(2, 4, -1, 0);
    send_digit(7, 4, -1, 0);
    send_digit(4, 4, -1, 0);
    send_digit(0, 4, -1, 0);
    drain("frame");
    n_checks++;
    if (fd_count != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d expected 1", fd_count);
    end
  endtask

  task automatic test_stall();
    test_reset();
    send_digit(5, 4, 1, 3);
    drain("stall");
  endtask

  task automatic test_bcd_check();
    test_reset();
    send_digit(10, 4, -1, 0);
    send_digit(8, 4, -1, 0);
    send_digit(15, 4, -1, 0);
    send_digit(9, 4, -1, 0);
    drain("bcd_check");
  endtask

  task automatic test_reset_mid_frame();
    test_reset();
    send_digit(2, 4, -1, 0);
    send_digit(1, 2, -1, 0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out, out_valid, frame_done, digit_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0000", {out, out_valid, frame_done, digit_err});
    end
    q.delete();
    model_dig = 0;
    fd_count  = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    send_digit(3, 4, -1, 0);
    send_digit(6, 4, -1, 0);
    send_digit(9, 4, -1, 0);
    drain("reset_mid");
    n_checks++;
    if (fd_count != 0) begin
      n_fail++;
      $display("FAIL early_frame_done: got %0d expected 0", fd_count);
    end
    send_digit(4, 4, -1, 0);
    drain("reset_mid_full");
    n_checks++;
    if (fd_count != 1) begin
      n_fail++;
      $display("FAIL frame_after_reset: got %0d expected 1", fd_count);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 3 * NUM_DIGITS; i++) begin
      send_digit(int'($urandom_range(0, 15)), 4, -1, 0);
    end
    drain("back_to_back");
    n_checks++;
    if (fd_count != 3) begin
      n_fail++;
      $display("FAIL b2b_frame_count: got %0d expected 3", fd_count);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_digit5();
    test_carry_boundary();
    test_frame();
    test_stall();
    test_bcd_check();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
